// File: rtl/mem_stream_initiator.sv
// mem_stream_initiator: turns framed command bytes from a host byte stream
// into single 32-bit reads/writes on the memory-mapped peripheral bus and
// returns a status byte (plus read data) on an outgoing byte stream.
//
// Handshakes: a byte moves on in_*/out_* when valid && ready are both high
// on a rising clock edge; out_valid/out_data depend on state only and stay
// put until accepted. On the bus side mem_valid is held with constant
// addr/wdata/wstrb until the first cycle that mem_ready is high, or until
// TIMEOUT cycles have passed (TIMEOUT must be at least 1).
module mem_stream_initiator #(
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   input  logic        mem_error,
   output logic [2:0]  dbg_state
);

   // Wait counter only needs to reach TIMEOUT-1 before the abort fires.
   localparam int             TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_MEMERR  = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BADOP   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_DATA   = 3'd2,
      S_BUS    = 3'd3,
      S_STATUS = 3'd4,
      S_RDATA  = 3'd5
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_is_write;
   logic [1:0]    r_cnt;        // byte index within addr/data/rdata
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic [1:0]    r_status;
   logic [TW-1:0] r_tmo_cnt;
   logic          w_in_fire;
   logic          w_out_fire;
   logic          w_tmo_hit;

   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign dbg_state = r_state;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode and all handshake/bus strobes, driven from state only.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      mem_valid = 1'b0;
      mem_wstrb = 4'h0;
      w_tmo_hit = (r_tmo_cnt == TMO_LAST);
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data == OP_WRITE || in_data == OP_READ) w_next = S_ADDR;
               else                                           w_next = S_STATUS;
            end
         end
         S_ADDR: begin
            in_ready = 1'b1;
            if (in_valid && r_cnt == 2'd3) w_next = r_is_write ? S_DATA : S_BUS;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid && r_cnt == 2'd3) w_next = S_BUS;
         end
         S_BUS: begin
            mem_valid = 1'b1;
            mem_wstrb = r_is_write ? 4'hF : 4'h0;
            // A completion on the expiry cycle wins over the timeout.
            if (mem_ready || w_tmo_hit) w_next = S_STATUS;
         end
         S_STATUS: begin
            out_valid = 1'b1;
            out_data  = {6'b0, r_status};
            if (out_ready) w_next = (!r_is_write && r_status == ST_OK) ? S_RDATA : S_IDLE;
         end
         S_RDATA: begin
            out_valid = 1'b1;
            out_data  = r_rdata[{r_cnt, 3'b000} +: 8];
            if (out_ready && r_cnt == 2'd3) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
      w_in_fire  = in_valid && in_ready;
      w_out_fire = out_valid && out_ready;
   end

   // Frame assembly, bus result capture and response byte sequencing.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_is_write <= 1'b0;
         r_cnt      <= 2'd0;
         r_addr     <= 32'h0;
         r_wdata    <= 32'h0;
         r_rdata    <= 32'h0;
         r_status   <= ST_OK;
         r_tmo_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_in_fire) begin
                  r_is_write <= (in_data == OP_WRITE);
                  r_cnt      <= 2'd0;
                  // Only survives to STATUS when the opcode is rejected.
                  r_status   <= ST_BADOP;
               end
            end
            S_ADDR: begin
               if (w_in_fire) begin
                  r_addr[{r_cnt, 3'b000} +: 8] <= in_data;
                  r_cnt <= r_cnt + 2'd1;   // wraps to 0, ready for DATA
               end
            end
            S_DATA: begin
               if (w_in_fire) begin
                  r_wdata[{r_cnt, 3'b000} +: 8] <= in_data;
                  r_cnt <= r_cnt + 2'd1;
               end
            end
            S_BUS: begin
               if (mem_ready) begin
                  r_rdata  <= mem_rdata;
                  r_status <= mem_error ? ST_MEMERR : ST_OK;
               end else if (w_tmo_hit) begin
                  r_status <= ST_TIMEOUT;
               end
            end
            S_STATUS: r_cnt <= 2'd0;
            S_RDATA: begin
               if (w_out_fire) r_cnt <= r_cnt + 2'd1;
            end
            default: r_cnt <= 2'd0;
         endcase
         // Counter runs only while waiting on the bus; cleared everywhere else
         // so every BUS entry starts from zero.
         if (r_state == S_BUS) r_tmo_cnt <= r_tmo_cnt + TW'(1);
         else                  r_tmo_cnt <= '0;
      end
   end

endmodule
